display_scan_scheduler: RTL and testbench

- Sequences the four-digit time-multiplexed seven-segment display.
- Generates the digit-scan order and dwell timing.
- Holds the four 8-bit digit values that feed the time multiplexer's `in1`..`in4`.
- Accepts value updates from the processor over a req/ack handshake and commits them only at a frame boundary, so a displayed frame never mixes old and new digits.

---
 rtl/display_scan_scheduler.sv | 173 +++++++++++++++++
 tb/tb_display_scan_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler
//
// Sequences a four-digit time-multiplexed seven-segment display. A prescaler
// sets the per-digit dwell, the scan counter picks the digit being driven, and
// a small handshake FSM takes new digit values from the processor and commits
// them only at a frame boundary, so a displayed frame never mixes old and new
// digits.
//
// Optional feature: define SCAN_SKIP_EN to skip disabled digits entirely
// instead of scanning them dark.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   upd_req      update request level, held until upd_ack
//   upd_data     new digit values: [7:0]->in1 .. [31:24]->in4
//   digit_en     per-digit enable, bit i = digit i
//   upd_ack      one-cycle pulse, update committed
//   busy         update captured, awaiting commit
//   scan_sel     digit currently driven (0..3)
//   blank        current digit must be dark
//   frame_start  one-cycle pulse when the scan wraps
//   in1..in4     committed digit values for the time multiplexer

module display_scan_scheduler #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        upd_req,
    input  logic [31:0] upd_data,
    input  logic [3:0]  digit_en,
    output logic        upd_ack,
    output logic        busy,
    output logic [1:0]  scan_sel,
    output logic        blank,
    output logic        frame_start,
    output logic [7:0]  in1,
    output logic [7:0]  in2,
    output logic [7:0]  in3,
    output logic [7:0]  in4
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPending,
        StAck,
        StWaitLow
    } upd_state_e;

    logic [CntW-1:0] div_cnt_q;
    logic            tick;
    logic [1:0]      scan_sel_q, scan_sel_d;
    logic            wrap;
    logic            blank_q;
    logic            frame_start_q;
    logic [31:0]     staging_q, staging_d;
    logic [31:0]     digits_q;
    logic            commit;
    upd_state_e      state_q, state_d;

    assign tick = (div_cnt_q == CntMax);

    // Next digit and wrap detection. A wrap is the advance that starts a new
    // frame; commit and frame_start both key off it.
`ifdef SCAN_SKIP_EN
    logic [1:0] idx;
    logic       found;

    always_comb begin
        scan_sel_d = scan_sel_q;
        wrap       = 1'b0;
        idx        = 2'd0;
        found      = 1'b0;
        if (tick) begin
            if (digit_en == 4'b0000) begin
                // Nothing to show: hold position, but keep frames ticking so
                // pending updates still commit.
                wrap = 1'b1;
            end else begin
                // k == 4 lands back on the current digit (only one enabled).
                for (int k = 1; k <= 4; k++) begin
                    idx = scan_sel_q + 2'(k);
                    if (!found && digit_en[idx]) begin
                        scan_sel_d = idx;
                        found      = 1'b1;
                    end
                end
                wrap = (scan_sel_d <= scan_sel_q);
            end
        end
    end
`else
    always_comb begin
        scan_sel_d = scan_sel_q;
        wrap       = 1'b0;
        if (tick) begin
            scan_sel_d = scan_sel_q + 2'd1;
            wrap       = (scan_sel_q == 2'd3);
        end
    end
`endif

    // Update handshake: capture in idle, commit on a wrap, ack once, then wait
    // for the request to drop so a held request never recaptures.
    always_comb begin
        state_d   = state_q;
        staging_d = staging_q;
        commit    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (upd_req) begin
                    staging_d = upd_data;
                    state_d   = StPending;
                end
            end
            StPending: begin
                if (wrap) begin
                    commit  = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StWaitLow;
            end
            StWaitLow: begin
                if (!upd_req) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q     <= '0;
            scan_sel_q    <= 2'd0;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
            staging_q     <= '0;
            digits_q      <= '0;
            state_q       <= StIdle;
        end else begin
            div_cnt_q     <= tick ? '0 : div_cnt_q + 1'b1;
            scan_sel_q    <= scan_sel_d;
            // Blank tracks the digit that will be driven next cycle.
            blank_q       <= ~digit_en[scan_sel_d];
            frame_start_q <= wrap;
            staging_q     <= staging_d;
            if (commit) begin
                digits_q <= staging_q;
            end
            state_q <= state_d;
        end
    end

    assign upd_ack     = (state_q == StAck);
    assign busy        = (state_q == StPending);
    assign scan_sel    = scan_sel_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;
    assign in1         = digits_q[7:0];
    assign in2         = digits_q[15:8];
    assign in3         = digits_q[23:16];
    assign in4         = digits_q[31:24];

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Bench for display_scan_scheduler with REFRESH_DIV = 4. Stimulus pushes the
// expected commit (digit values and number of frame_start pulses until the
// ack) into a queue; a monitor pops it when upd_ack appears.

module tb_display_scan_scheduler;

    typedef struct {
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] e3;
        logic [7:0] e4;
        int         frames;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        upd_req = 1'b0;
    logic [31:0] upd_data = '0;
    logic [3:0]  digit_en = 4'b1111;
    logic        upd_ack;
    logic        busy;
    logic [1:0]  scan_sel;
    logic        blank;
    logic        frame_start;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic [7:0]  in3;
    logic [7:0]  in4;

    int   checks = 0;
    int   errors = 0;
    int   k = 0;
    int   fcnt = 0;
    exp_t q[$];

    display_scan_scheduler #(.REFRESH_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .upd_req     (upd_req),
        .upd_data    (upd_data),
        .digit_en    (digit_en),
        .upd_ack     (upd_ack),
        .busy        (busy),
        .scan_sel    (scan_sel),
        .blank       (blank),
        .frame_start (frame_start),
        .in1         (in1),
        .in2         (in2),
        .in3         (in3),
        .in4         (in4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at k=%0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input int frames);
        exp_t e;
        e.e1 = a;
        e.e2 = b;
        e.e3 = c;
        e.e4 = d;
        e.frames = frames;
        q.push_back(e);
    endtask

    // Monitor: counts frame_start pulses for the head entry and checks the ack.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() == 0) begin
                fcnt = 0;
            end else if (frame_start) begin
                fcnt++;
            end
            if (upd_ack) begin
                if (q.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("ack_frame", 32'(fcnt), 32'(e.frames));
                    chk("ack_in1", {24'd0, in1}, {24'd0, e.e1});
                    chk("ack_in2", {24'd0, in2}, {24'd0, e.e2});
                    chk("ack_in3", {24'd0, in3}, {24'd0, e.e3});
                    chk("ack_in4", {24'd0, in4}, {24'd0, e.e4});
                    chk("ack_busy", {31'd0, busy}, 32'd0);
                    fcnt = 0;
                end
            end else if (q.size() != 0 && fcnt > q[0].frames) begin
                chk("ack_overdue", 32'(fcnt), 32'(q[0].frames));
                void'(q.pop_front());
                fcnt = 0;
            end
        end
    end

    initial begin
        #100us;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_scan;
        int exp_fs;
        int exp_blank;

        // Reset held three cycles.
        step(3);
        chk("rst_scan_sel", {30'd0, scan_sel}, 32'd0);
        chk("rst_blank", {31'd0, blank}, 32'd1);
        chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
        chk("rst_upd_ack", {31'd0, upd_ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in", {in4, in3, in2, in1}, 32'd0);

        // Scan order, dwell, frame_start and blanking with digit_en = 0101.
        digit_en = 4'b0101;
        reset = 1'b0;
        k = 0;
        for (int i = 1; i <= 32; i++) begin
            step(1);
`ifdef SCAN_SKIP_EN
            exp_scan  = ((k / 4) % 2) * 2;
            exp_fs    = (k % 8 == 0) ? 1 : 0;
            exp_blank = 0;
`else
            exp_scan  = (k / 4) % 4;
            exp_fs    = (k % 16 == 0) ? 1 : 0;
            exp_blank = (exp_scan == 1 || exp_scan == 3) ? 1 : 0;
`endif
            chk("scan_sel", {30'd0, scan_sel}, 32'(exp_scan));
            chk("frame_start", {31'd0, frame_start}, 32'(exp_fs));
            chk("blank", {31'd0, blank}, 32'(exp_blank));
        end

        // Basic update mid-frame; request then held high long after the ack.
        step(5);
        upd_req  = 1'b1;
        upd_data = 32'h0804_0502;
        push(8'h02, 8'h05, 8'h04, 8'h08, 1);
        step(1);
        chk("upd_busy", {31'd0, busy}, 32'd1);
        chk("upd_in_before", {in4, in3, in2, in1}, 32'd0);
        chk("upd_ack_early", {31'd0, upd_ack}, 32'd0);
        step(42);
        upd_req = 1'b0;
        step(1);
        chk("upd_done", 32'(q.size()), 32'd0);
        chk("upd_busy_after", {31'd0, busy}, 32'd0);
        chk("upd_in_hold", {in4, in3, in2, in1}, 32'h0804_0502);

        // Request arrives in the same cycle as the wrap tick (k = 95 -> edge 96).
        step(14);
        upd_req  = 1'b1;
        upd_data = 32'hA1B2_C3D4;
        push(8'hD4, 8'hC3, 8'hB2, 8'hA1, 2);
        step(1);
        chk("coll_frame_start", {31'd0, frame_start}, 32'd1);
        chk("coll_busy", {31'd0, busy}, 32'd1);
        chk("coll_in_old", {in4, in3, in2, in1}, 32'h0804_0502);
        step(34);
        upd_req = 1'b0;
        step(1);
        chk("coll_done", 32'(q.size()), 32'd0);

        // Reset while pending: no ack, values cleared.
        step(9);
        upd_req  = 1'b1;
        upd_data = 32'h1122_3344;
        step(2);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset   = 1'b1;
        upd_req = 1'b0;
        step(2);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ack", {31'd0, upd_ack}, 32'd0);
        chk("mid_rst_in", {in4, in3, in2, in1}, 32'd0);
        reset = 1'b0;
        k = 0;
        step(5);
        upd_req  = 1'b1;
        upd_data = 32'h5566_7788;
        push(8'h88, 8'h77, 8'h66, 8'h55, 1);
        step(25);
        upd_req = 1'b0;
        step(1);
        chk("rereq_done", 32'(q.size()), 32'd0);
        chk("rereq_in", {in4, in3, in2, in1}, 32'h5566_7788);

`ifdef SCAN_SKIP_EN
        // No digit enabled: scan holds at 2, blank, every tick is a wrap.
        step(14);
        digit_en = 4'b0000;
        step(1);
        upd_req  = 1'b1;
        upd_data = 32'h0F0E_0D0C;
        push(8'h0C, 8'h0D, 8'h0E, 8'h0F, 1);
        step(1);
        chk("dis_blank", {31'd0, blank}, 32'd1);
        step(8);
        chk("dis_scan_hold", {30'd0, scan_sel}, 32'd2);
        chk("dis_blank_hold", {31'd0, blank}, 32'd1);
        step(5);
        upd_req = 1'b0;
        step(1);
        chk("dis_done", 32'(q.size()), 32'd0);
        digit_en = 4'b0101;
`endif

        step(4);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
